// File: rtl/hazard_forward_unit.sv
// Execute-stage hazard unit: MX/WX bypass flags, load-use stall, redirect flush and squash.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_forward_unit #(
  parameter int unsigned SQUASH_DEPTH = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              e_valid,
  input  logic [6:0]        e_opcode,
  input  logic [4:0]        e_rs1,
  input  logic [4:0]        e_rs2,
  input  logic [4:0]        e_rd,
  input  logic              e_write_enable,
  input  logic [1:0]        e_wb_select,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic [31:0]       m_result,
  input  logic [31:0]       w_result,
  output logic              mx_rs1_flag,
  output logic              mx_rs2_flag,
  output logic [31:0]       mx_data_forwarded,
  output logic              wx_rs1_flag,
  output logic              wx_rs2_flag,
  output logic [31:0]       wx_data_forwarded,
  output logic              stall,
  output logic              flush,
  output logic              kill_e
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
`endif
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [1:0] SquashLoad = SQUASH_DEPTH[1:0];

  // Tracking of the two instructions ahead of execute.
  logic       m_valid_q, m_valid_d;
  logic [4:0] m_rd_q, m_rd_d;
  logic       m_we_q, m_we_d;
  logic       m_load_q, m_load_d;
  logic       w_valid_q, w_valid_d;
  logic [4:0] w_rd_q, w_rd_d;
  logic       w_we_q, w_we_d;
  logic [1:0] squash_cnt_q, squash_cnt_d;

  logic rs1_used, rs2_used;
  logic live;
  logic match_m_rs1, match_m_rs2, match_w_rs1, match_w_rs2;

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (e_opcode)
      OpLui, OpAuipc, OpJal: begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
      end
      OpJalr, OpLoad, OpImm: begin
        rs1_used = 1'b1;
      end
      OpBranch, OpStore, OpReg: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      default: begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
      end
    endcase
  end

  assign kill_e = (squash_cnt_q != 2'd0);
  assign live   = e_valid & ~kill_e;

  // x0 is never a forwarding source, so a zero destination never matches.
  assign match_m_rs1 = m_valid_q & m_we_q & (m_rd_q != 5'd0) & (m_rd_q == e_rs1) & rs1_used & live;
  assign match_m_rs2 = m_valid_q & m_we_q & (m_rd_q != 5'd0) & (m_rd_q == e_rs2) & rs2_used & live;
  assign match_w_rs1 = w_valid_q & w_we_q & (w_rd_q != 5'd0) & (w_rd_q == e_rs1) & rs1_used & live;
  assign match_w_rs2 = w_valid_q & w_we_q & (w_rd_q != 5'd0) & (w_rd_q == e_rs2) & rs2_used & live;

  always_comb begin
    stall       = (match_m_rs1 | match_m_rs2) & m_load_q;
    mx_rs1_flag = match_m_rs1 & ~m_load_q & ~stall;
    mx_rs2_flag = match_m_rs2 & ~m_load_q & ~stall;
    // M has priority over W for the same source.
    wx_rs1_flag = match_w_rs1 & ~match_m_rs1 & ~stall;
    wx_rs2_flag = match_w_rs2 & ~match_m_rs2 & ~stall;
    flush       = live & ~stall & (branch_taken | jump);

    mx_data_forwarded = (mx_rs1_flag | mx_rs2_flag) ? m_result : 32'd0;
    wx_data_forwarded = (wx_rs1_flag | wx_rs2_flag) ? w_result : 32'd0;
  end

  always_comb begin
    // A stalled slot leaves a bubble in M; W keeps draining.
    m_valid_d = live & ~stall;
    m_rd_d    = e_rd;
    m_we_d    = e_write_enable;
    m_load_d  = (e_wb_select == 2'b01);
    w_valid_d = m_valid_q;
    w_rd_d    = m_rd_q;
    w_we_d    = m_we_q;

    squash_cnt_d = squash_cnt_q;
    if (flush) begin
      squash_cnt_d = SquashLoad;
    end else if (squash_cnt_q != 2'd0) begin
      squash_cnt_d = squash_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_valid_q    <= 1'b0;
      m_rd_q       <= 5'd0;
      m_we_q       <= 1'b0;
      m_load_q     <= 1'b0;
      w_valid_q    <= 1'b0;
      w_rd_q       <= 5'd0;
      w_we_q       <= 1'b0;
      squash_cnt_q <= 2'd0;
    end else begin
      m_valid_q    <= m_valid_d;
      m_rd_q       <= m_rd_d;
      m_we_q       <= m_we_d;
      m_load_q     <= m_load_d;
      w_valid_q    <= w_valid_d;
      w_rd_q       <= w_rd_d;
      w_we_q       <= w_we_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_count_q, flush_count_q;

  // Saturating event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (stall && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
      if (flush && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: directed pipeline sequence with hand-derived flags.
module tb_hazard_forward_unit;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        e_valid = 1'b0;
  logic [6:0]  e_opcode = 7'd0;
  logic [4:0]  e_rs1 = 5'd0, e_rs2 = 5'd0, e_rd = 5'd0;
  logic        e_write_enable = 1'b0;
  logic [1:0]  e_wb_select = 2'b00;
  logic        branch_taken = 1'b0, jump = 1'b0;
  logic [31:0] m_result = 32'd0, w_result = 32'd0;
  logic        mx_rs1_flag, mx_rs2_flag, wx_rs1_flag, wx_rs2_flag;
  logic [31:0] mx_data_forwarded, wx_data_forwarded;
  logic        stall, flush, kill_e;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count, flush_count;
`endif

  hazard_forward_unit dut (
    .clock             (clock),
    .reset             (reset),
    .e_valid           (e_valid),
    .e_opcode          (e_opcode),
    .e_rs1             (e_rs1),
    .e_rs2             (e_rs2),
    .e_rd              (e_rd),
    .e_write_enable    (e_write_enable),
    .e_wb_select       (e_wb_select),
    .branch_taken      (branch_taken),
    .jump              (jump),
    .m_result          (m_result),
    .w_result          (w_result),
    .mx_rs1_flag       (mx_rs1_flag),
    .mx_rs2_flag       (mx_rs2_flag),
    .mx_data_forwarded (mx_data_forwarded),
    .wx_rs1_flag       (wx_rs1_flag),
    .wx_rs2_flag       (wx_rs2_flag),
    .wx_data_forwarded (wx_data_forwarded),
    .stall             (stall),
    .flush             (flush),
    .kill_e            (kill_e)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count       (stall_count),
    .flush_count       (flush_count)
`endif
  );

  always #5 clock = ~clock;

  // flags = {mx1, mx2, wx1, wx2, stall, flush, kill}
  typedef struct packed {
    logic [6:0]  flags;
    logic [31:0] mxd;
    logic [31:0] wxd;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    checks = 0;
  int    errors = 0;
  int    step_n = 0;

  task automatic step(input logic rst, input logic v, input logic [6:0] op,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic we, input logic [1:0] wb, input logic br, input logic jmp,
                      input logic [6:0] flags, input string name);
    exp_t e;
    @(posedge clock);
    #1;
    step_n++;
    reset          = rst;
    e_valid        = v;
    e_opcode       = op;
    e_rs1          = rs1;
    e_rs2          = rs2;
    e_rd           = rd;
    e_write_enable = we;
    e_wb_select    = wb;
    branch_taken   = br;
    jump           = jmp;
    m_result       = 32'h1000_0000 + 32'(step_n);
    w_result       = 32'h2000_0000 + 32'(step_n);
    e.flags = flags;
    e.mxd   = (flags[6] | flags[5]) ? m_result : 32'd0;
    e.wxd   = (flags[4] | flags[3]) ? w_result : 32'd0;
    sb.push_back(e);
    sb_name.push_back(name);
  endtask

  // Monitor: the DUT presents a fresh result every cycle; compare mid-cycle.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string n;
      e = sb.pop_front();
      n = sb_name.pop_front();
      a.flags = {mx_rs1_flag, mx_rs2_flag, wx_rs1_flag, wx_rs2_flag, stall, flush, kill_e};
      a.mxd   = mx_data_forwarded;
      a.wxd   = wx_data_forwarded;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got flags=%b mxd=%h wxd=%h, expected flags=%b mxd=%h wxd=%h",
                 n, a.flags, a.mxd, a.wxd, e.flags, e.mxd, e.wxd);
      end
    end
  end

  initial begin
    step(1, 0, OpReg,    0,  0,  0, 0, 2'b00, 0, 0, 7'b0000000, "reset0");
    step(1, 0, OpReg,    0,  0,  0, 0, 2'b00, 0, 0, 7'b0000000, "reset1");
    step(0, 1, OpImm,    1,  0,  5, 1, 2'b00, 0, 0, 7'b0000000, "addi_x5");
    step(0, 1, OpReg,    5,  7,  6, 1, 2'b00, 0, 0, 7'b1000000, "mx_rs1");
    step(0, 1, OpImm,    0,  0,  5, 1, 2'b00, 0, 0, 7'b0000000, "addi_x5_a");
    step(0, 1, OpImm,    0,  0,  5, 1, 2'b00, 0, 0, 7'b0000000, "addi_x5_b");
    step(0, 1, OpReg,    9,  5,  8, 1, 2'b00, 0, 0, 7'b0100000, "mx_rs2_priority");
    step(0, 1, OpReg,    1,  5, 10, 1, 2'b00, 0, 0, 7'b0001000, "wx_rs2");
    step(0, 1, OpLoad,   2,  0,  5, 1, 2'b01, 0, 0, 7'b0000000, "lw_x5");
    step(0, 1, OpReg,    5,  0,  6, 1, 2'b00, 0, 0, 7'b0000100, "load_use_stall");
    step(0, 1, OpReg,    5,  0,  6, 1, 2'b00, 0, 0, 7'b0010000, "wx_after_stall");
    step(0, 1, OpImm,    3,  0,  0, 1, 2'b00, 0, 0, 7'b0000000, "write_x0");
    step(0, 1, OpReg,    0,  0, 11, 1, 2'b00, 0, 0, 7'b0000000, "read_x0");
    step(0, 1, OpLui,   11, 11, 12, 1, 2'b00, 0, 0, 7'b0000000, "lui_no_src");
    step(0, 1, OpBranch, 1,  2,  0, 0, 2'b00, 1, 0, 7'b0000010, "beq_flush");
    step(0, 1, OpReg,   12,  0, 13, 1, 2'b00, 1, 0, 7'b0000001, "killed_1");
    step(0, 1, OpReg,   12,  0, 13, 1, 2'b00, 0, 0, 7'b0000001, "killed_2");
    step(0, 1, OpImm,    0,  0, 14, 1, 2'b00, 0, 0, 7'b0000000, "post_squash");
    step(0, 1, OpReg,   14,  0, 15, 1, 2'b00, 0, 0, 7'b1000000, "mx_again");
    step(0, 1, OpJal,    0,  0,  1, 1, 2'b00, 0, 1, 7'b0000010, "jal_flush");
    step(1, 1, OpReg,    1,  0,  2, 1, 2'b00, 0, 0, 7'b0000001, "reset_mid_squash");
    step(0, 1, OpReg,    1,  0,  2, 1, 2'b00, 0, 0, 7'b0000000, "after_reset");
`ifdef HAZARD_STATS_EN
    #1;
    checks++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
      errors++;
      $display("FAIL stats_after_reset: got stall_count=%0d flush_count=%0d, expected 0 and 0",
               stall_count, flush_count);
    end
`endif
    step(0, 1, OpReg,    2,  0,  3, 1, 2'b00, 0, 0, 7'b1000000, "live_after_reset");
    step(0, 1, OpLoad,   0,  0,  5, 1, 2'b01, 0, 0, 7'b0000000, "lw_x5_b");
    step(0, 1, OpBranch, 5,  0,  0, 0, 2'b00, 1, 0, 7'b0000100, "stall_blocks_flush");
    step(0, 1, OpBranch, 5,  0,  0, 0, 2'b00, 1, 0, 7'b0010010, "wx_branch_flush");
    step(0, 0, OpReg,    0,  0,  0, 0, 2'b00, 0, 0, 7'b0000001, "idle_killed_1");
    step(0, 0, OpReg,    0,  0,  0, 0, 2'b00, 0, 0, 7'b0000001, "idle_killed_2");
    step(0, 0, OpReg,    0,  0,  0, 0, 2'b00, 0, 0, 7'b0000000, "idle_clean");

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clock);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
